// File: rtl/seq_pkg.sv
// Shared definitions for the fetch/execute sequencer: opcodes, FSM states,
// SKIP condition encodings and the effective-address helper.
package seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_HALT  = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_CLEAR = 4'h4;
  localparam logic [3:0] OP_SKIP  = 4'h5;
  localparam logic [3:0] OP_JUMP  = 4'h6;

  localparam logic [1:0] SKIP_NEG   = 2'b00;
  localparam logic [1:0] SKIP_ZERO  = 2'b01;
  localparam logic [1:0] SKIP_POS   = 2'b10;
  localparam logic [1:0] SKIP_NEVER = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_HALT
  } state_t;

  // Operand is a byte offset; bit 0 is dropped so accesses stay word aligned.
  function automatic logic [15:0] eff_addr(input logic [11:0] operand);
    return {4'b0000, operand[11:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_exec_sequencer_if.sv
// Request/acknowledge memory bus between the sequencer (master) and memory (slave).
interface fetch_exec_sequencer_if;

  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/seq_skip_eval.sv
// Combinational SKIP condition evaluation from the accumulator and operand[11:10].
module seq_skip_eval
  import seq_pkg::*;
(
  input  logic [15:0] acc,
  input  logic [1:0]  cond,
  output logic        skip
);

  always_comb begin
    skip = 1'b0;
    unique case (cond)
      SKIP_NEG:   skip = acc[15];
      SKIP_ZERO:  skip = (acc == 16'h0000);
      SKIP_POS:   skip = !acc[15] && (acc != 16'h0000);
      SKIP_NEVER: skip = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer with a single accumulator.
// Define FETCH_EXEC_SEQUENCER_TRAP_EN to halt and flag illegal on undefined opcodes.
module fetch_exec_sequencer
  import seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  fetch_exec_sequencer_if.master        bus,
  output logic [15:0]                   pc,
  output logic [15:0]                   ir,
  output logic [15:0]                   acc,
  output logic                          halted,
  output logic                          illegal
);

  state_t      state;
  state_t      next_state;
  logic [3:0]  opcode;
  logic [15:0] ea;
  logic        skip;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;

  assign opcode = ir[15:12];
  assign ea     = eff_addr(ir[11:0]);

  seq_skip_eval u_skip_eval (
    .acc  (acc),
    .cond (ir[11:10]),
    .skip (skip)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_FETCH;
      ST_FETCH:  if (bus.mem_ack) next_state = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_ADD, OP_LOAD, OP_STORE:   next_state = ST_MEM;
          OP_HALT:                     next_state = ST_HALT;
          OP_CLEAR, OP_SKIP, OP_JUMP:  next_state = ST_FETCH;
`ifdef FETCH_EXEC_SEQUENCER_TRAP_EN
          default:                     next_state = ST_HALT;
`else
          default:                     next_state = ST_FETCH;
`endif
        endcase
      end
      ST_MEM:    if (bus.mem_ack) next_state = ST_FETCH;
      ST_HALT:   next_state = ST_HALT;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Bus outputs decode purely from state, so an async reset drops mem_req at once.
  always_comb begin
    req    = 1'b0;
    we     = 1'b0;
    addr   = 16'h0000;
    wdata  = 16'h0000;
    halted = 1'b0;
    case (state)
      ST_FETCH: begin
        req  = 1'b1;
        addr = pc;
      end
      ST_MEM: begin
        req  = 1'b1;
        addr = ea;
        if (opcode == OP_STORE) begin
          we    = 1'b1;
          wdata = acc;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_req   = req;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc  <= RESET_PC;
      ir  <= 16'h0000;
      acc <= 16'h0000;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bus.mem_ack) begin
            ir <= bus.mem_rdata;
            pc <= pc + 16'd2;
          end
        end
        ST_DECODE: begin
          case (opcode)
            OP_CLEAR: acc <= 16'h0000;
            OP_JUMP:  pc  <= ea;
            OP_SKIP:  if (skip) pc <= pc + 16'd2;
            default:  ;
          endcase
        end
        ST_MEM: begin
          if (bus.mem_ack) begin
            if (opcode == OP_LOAD)     acc <= bus.mem_rdata;
            else if (opcode == OP_ADD) acc <= acc + bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_EXEC_SEQUENCER_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        illegal <= 1'b0;
    else if (state == ST_DECODE && opcode > OP_JUMP)  illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Directed bench for fetch_exec_sequencer: table of small programs plus
// hand-driven handshake, wrap, jump and reset-abort sequences.
module tb_fetch_exec_sequencer;

  typedef struct {
    string       name;
    logic [15:0] p0, p1, p2, p3;
    logic [15:0] d40, d42;
    int          dly;
    logic [15:0] exp_acc;
    logic [15:0] exp_pc;
    logic        exp_ill;
    int          exp_nst;
    logic [15:0] exp_saddr;
    logic [15:0] exp_sdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start2;
  logic [15:0] pc, ir, acc, pc2, ir2, acc2;
  logic        halted, illegal, halted2, illegal2;

  logic        mem_auto;
  int          ack_delay;
  logic        man_ack, man2_ack;
  logic [15:0] man_rdata, man2_rdata;
  logic [15:0] mem [0:127];
  logic        auto_ack;
  logic [15:0] auto_rdata;
  int          wait_cnt;
  int          store_cnt;
  logic [15:0] store_addr, store_data;

  int          checks = 0;
  int          failures = 0;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  fetch_exec_sequencer_if bus ();
  fetch_exec_sequencer_if bus2 ();

  fetch_exec_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .pc(pc), .ir(ir), .acc(acc), .halted(halted), .illegal(illegal)
  );

  fetch_exec_sequencer #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bus(bus2),
    .pc(pc2), .ir(ir2), .acc(acc2), .halted(halted2), .illegal(illegal2)
  );

  assign bus.mem_ack    = mem_auto ? auto_ack : man_ack;
  assign bus.mem_rdata  = mem_auto ? auto_rdata : man_rdata;
  assign bus2.mem_ack   = man2_ack;
  assign bus2.mem_rdata = man2_rdata;

  // Memory model: acks after ack_delay wait cycles, logs stores rather than writing.
  always @(negedge clk) begin
    auto_ack = 1'b0;
    if (mem_auto && bus.mem_req) begin
      if (wait_cnt >= ack_delay) begin
        auto_ack   = 1'b1;
        auto_rdata = mem[bus.mem_addr[7:1]];
        wait_cnt   = 0;
        if (bus.mem_we) begin
          store_cnt  = store_cnt + 1;
          store_addr = bus.mem_addr;
          store_data = bus.mem_wdata;
        end
      end else begin
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  initial begin
    auto_ack   = 1'b0;
    auto_rdata = 16'h0000;
    wait_cnt   = 0;
    store_cnt  = 0;
    store_addr = 16'h0000;
    store_data = 16'h0000;
  end

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic add_vec(input string name, input logic [15:0] p0, p1, p2, p3, d40, d42,
                         input int dly, input logic [15:0] eacc, epc, input logic eill,
                         input int nst, input logic [15:0] saddr, sdata);
    vec_t v;
    v.name = name; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
    v.d40 = d40; v.d42 = d42; v.dly = dly; v.exp_acc = eacc; v.exp_pc = epc;
    v.exp_ill = eill; v.exp_nst = nst; v.exp_saddr = saddr; v.exp_sdata = sdata;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic apply_stimulus_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic load_prog(input logic [15:0] p0, p1, p2, p3, d40, d42);
    for (int i = 0; i < 128; i++) mem[i] = 16'h1000;
    mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[3] = p3;
    mem[32] = d40; mem[33] = d42;
  endtask

  task automatic run_until_halt(input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(posedge clk);
      #1 cycles++;
    end
  endtask

  task automatic man_ack_word(input logic [15:0] data);
    int n;
    n = 0;
    while (!bus.mem_req && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check_output("man_req_seen", {15'd0, bus.mem_req}, 16'd1);
    man_ack   = 1'b1;
    man_rdata = data;
    @(posedge clk);
    #1 man_ack = 1'b0;
  endtask

  initial begin
    int cyc;
    int base;
    int stable;
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    mem_auto = 1'b1; ack_delay = 0;
    man_ack = 1'b0; man_rdata = 16'h0000; man2_ack = 1'b0; man2_rdata = 16'h0000;
    load_prog(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0000, 16'h0000);

    add_vec("ld_add_st",   16'h2040, 16'h0042, 16'h3044, 16'h1000, 16'h0005, 16'h0003, 0, 16'h0008, 16'h0008, 1'b0, 1, 16'h0044, 16'h0008);
    add_vec("add_wrap",    16'h2040, 16'h0042, 16'h1000, 16'h1000, 16'hFFFF, 16'h0002, 2, 16'h0001, 16'h0006, 1'b0, 0, 16'h0000, 16'h0000);
    add_vec("clear",       16'h2040, 16'h4000, 16'h1000, 16'h1000, 16'h1234, 16'h0000, 1, 16'h0000, 16'h0006, 1'b0, 0, 16'h0000, 16'h0000);
    add_vec("skip_neg_t",  16'h2040, 16'h5000, 16'h2042, 16'h1000, 16'h8000, 16'h1111, 0, 16'h8000, 16'h0008, 1'b0, 0, 16'h0000, 16'h0000);
    add_vec("skip_neg_n",  16'h2040, 16'h5000, 16'h2042, 16'h1000, 16'h0001, 16'h1111, 0, 16'h1111, 16'h0008, 1'b0, 0, 16'h0000, 16'h0000);
    add_vec("skip_zero_t", 16'h4000, 16'h5400, 16'h2042, 16'h1000, 16'h0000, 16'h1111, 0, 16'h0000, 16'h0008, 1'b0, 0, 16'h0000, 16'h0000);
    add_vec("skip_zero_n", 16'h2040, 16'h5400, 16'h2042, 16'h1000, 16'h0001, 16'h1111, 1, 16'h1111, 16'h0008, 1'b0, 0, 16'h0000, 16'h0000);
    add_vec("skip_pos_t",  16'h2040, 16'h5800, 16'h2042, 16'h1000, 16'h0001, 16'h1111, 0, 16'h0001, 16'h0008, 1'b0, 0, 16'h0000, 16'h0000);
    add_vec("skip_pos_0",  16'h4000, 16'h5800, 16'h2042, 16'h1000, 16'h0000, 16'h1111, 0, 16'h1111, 16'h0008, 1'b0, 0, 16'h0000, 16'h0000);
    add_vec("skip_pos_ng", 16'h2040, 16'h5800, 16'h2042, 16'h1000, 16'h8000, 16'h1111, 0, 16'h1111, 16'h0008, 1'b0, 0, 16'h0000, 16'h0000);
    add_vec("skip_never",  16'h2040, 16'h5C00, 16'h2042, 16'h1000, 16'h8000, 16'h1111, 0, 16'h1111, 16'h0008, 1'b0, 0, 16'h0000, 16'h0000);
    add_vec("jump_odd",    16'h6007, 16'h2040, 16'h2042, 16'h1000, 16'h0AAA, 16'h0BBB, 0, 16'h0000, 16'h0008, 1'b0, 0, 16'h0000, 16'h0000);
    add_vec("store_wait",  16'h2040, 16'h3046, 16'h1000, 16'h1000, 16'h00C3, 16'h0000, 3, 16'h00C3, 16'h0006, 1'b0, 1, 16'h0046, 16'h00C3);
`ifdef FETCH_EXEC_SEQUENCER_TRAP_EN
    add_vec("illegal",     16'h7000, 16'h2040, 16'h1000, 16'h1000, 16'h00AA, 16'h0000, 0, 16'h0000, 16'h0002, 1'b1, 0, 16'h0000, 16'h0000);
`else
    add_vec("illegal",     16'h7000, 16'h2040, 16'h1000, 16'h1000, 16'h00AA, 16'h0000, 0, 16'h00AA, 16'h0006, 1'b0, 0, 16'h0000, 16'h0000);
`endif

    apply_stimulus_reset();
    #1;
    check_output("rst_pc",      pc,  16'h0000);
    check_output("rst_ir",      ir,  16'h0000);
    check_output("rst_acc",     acc, 16'h0000);
    check_output("rst_req",     {15'd0, bus.mem_req}, 16'd0);
    check_output("rst_halted",  {15'd0, halted}, 16'd0);
    check_output("rst_illegal", {15'd0, illegal}, 16'd0);
    check_output("rst_pc2",     pc2, 16'hFFFE);

    foreach (vecs[i]) begin
      load_prog(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].d40, vecs[i].d42);
      ack_delay = vecs[i].dly;
      mem_auto  = 1'b1;
      apply_stimulus_reset();
      base = store_cnt;
      apply_stimulus_start();
      run_until_halt(300, cyc);
      check_output({vecs[i].name, "_halted"},  {15'd0, halted}, 16'd1);
      check_output({vecs[i].name, "_acc"},     acc, vecs[i].exp_acc);
      check_output({vecs[i].name, "_pc"},      pc,  vecs[i].exp_pc);
      check_output({vecs[i].name, "_illegal"}, {15'd0, illegal}, {15'd0, vecs[i].exp_ill});
      check_output({vecs[i].name, "_nstores"}, 16'(store_cnt - base), 16'(vecs[i].exp_nst));
      if (vecs[i].exp_nst > 0) begin
        check_output({vecs[i].name, "_saddr"}, store_addr, vecs[i].exp_saddr);
        check_output({vecs[i].name, "_sdata"}, store_data, vecs[i].exp_sdata);
      end
    end

    // Zero-wait LOAD/ADD/STORE/HALT program takes 3+3+3+2 cycles.
    load_prog(16'h2040, 16'h0042, 16'h3044, 16'h1000, 16'h0005, 16'h0003);
    ack_delay = 0;
    apply_stimulus_reset();
    apply_stimulus_start();
    run_until_halt(300, cyc);
    check_output("prog_cycles", 16'(cyc), 16'd11);
    check_output("prog_halt_req", {15'd0, bus.mem_req}, 16'd0);

    // Delayed fetch of CLEAR: request held stable across all wait cycles.
    mem_auto = 1'b0;
    apply_stimulus_reset();
    apply_stimulus_start();
    man_ack_word(16'h2040);
    @(posedge clk); #1;
    man_ack_word(16'h0077);
    check_output("dly_acc_pre", acc, 16'h0077);
    stable = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.mem_req && !bus.mem_we && bus.mem_addr == 16'h0002) stable++;
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    check_output("dly_stable", 16'(stable), 16'd4);
    man_ack_word(16'h4000);
    check_output("dly_dec_req", {15'd0, bus.mem_req}, 16'd0);
    check_output("dly_dec_ir",  ir, 16'h4000);
    check_output("dly_dec_pc",  pc, 16'h0004);
    @(posedge clk); #1;
    check_output("dly_acc",     acc, 16'h0000);
    check_output("dly_addr",    bus.mem_addr, 16'h0004);

    // JUMP to the top of the 12-bit window.
    apply_stimulus_reset();
    apply_stimulus_start();
    man_ack_word(16'h6FFF);
    @(posedge clk); #1;
    check_output("jump_req",  {15'd0, bus.mem_req}, 16'd1);
    check_output("jump_addr", bus.mem_addr, 16'h0FFE);

    // pc wraps from FFFE to 0000 on the second instance.
    apply_stimulus_reset();
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    check_output("wrap_addr0", bus2.mem_addr, 16'hFFFE);
    man2_ack = 1'b1; man2_rdata = 16'h4000;
    @(posedge clk); #1 man2_ack = 1'b0;
    check_output("wrap_pc",    pc2, 16'h0000);
    @(posedge clk); #1;
    check_output("wrap_addr1", bus2.mem_addr, 16'h0000);

    // Reset while a STORE waits for its ack; the late ack must be ignored.
    apply_stimulus_reset();
    apply_stimulus_start();
    man_ack_word(16'h2040);
    @(posedge clk); #1;
    man_ack_word(16'h0055);
    man_ack_word(16'h3040);
    @(posedge clk); #1;
    check_output("abort_we",    {15'd0, bus.mem_we}, 16'd1);
    check_output("abort_addr",  bus.mem_addr, 16'h0040);
    check_output("abort_wdata", bus.mem_wdata, 16'h0055);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_output("abort_req",   {15'd0, bus.mem_req}, 16'd0);
    check_output("abort_we0",   {15'd0, bus.mem_we}, 16'd0);
    check_output("abort_acc",   acc, 16'h0000);
    @(negedge clk); reset = 1'b0;
    man_ack = 1'b1; man_rdata = 16'hBEEF;
    @(posedge clk); #1 man_ack = 1'b0;
    @(posedge clk); #1;
    check_output("late_req",    {15'd0, bus.mem_req}, 16'd0);
    check_output("late_acc",    acc, 16'h0000);
    check_output("late_ir",     ir, 16'h0000);
    check_output("late_pc",     pc, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
